// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared mode encodings and combinational binary/Gray mappings
//                for blocks that need the conversion without a register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    // Mode select encodings
    localparam logic MODE_BIN2GRAY = 1'b0;
    localparam logic MODE_GRAY2BIN = 1'b1;

    // Widest word the helper functions handle; narrower words are zero-extended
    // on the way in, which leaves both mappings unchanged in the low bits.
    localparam int GRAY_MAX_WIDTH = 64;

    // Reflected Gray encode: g = b ^ (b >> 1)
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] word
    );
        return word ^ (word >> 1);
    endfunction

    // Gray decode: prefix XOR running from the MSB down
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] word
    );
        logic [GRAY_MAX_WIDTH-1:0] w_bin;
        w_bin[GRAY_MAX_WIDTH-1] = word[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ word[i];
        end
        return w_bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_gray_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_gray_converter_if
//  Description : Data-path bundle for the binary/Gray converter. The master
//                side presents words; the slave side returns registered results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface binary_to_gray_converter_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             out_valid;
    logic             parity;

    modport master (
        output in_valid, mode, b,
        input  g, out_valid, parity
    );

    modport slave (
        input  in_valid, mode, b,
        output g, out_valid, parity
    );
endinterface
`default_nettype wire

// File: rtl/gray_xor_prefix.sv
`default_nettype none
// ============================================================================
//  Module      : gray_xor_prefix
//  Description : Combinational MSB-to-LSB prefix-XOR chain (Gray -> binary).
//                Bit i of the output is the XOR of input bits WIDTH-1 down to i.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_xor_prefix #(
    parameter int WIDTH = 3
) (
    input  wire logic [WIDTH-1:0] gray_in,
    output logic      [WIDTH-1:0] bin_out
);

    // The MSB passes straight through; each lower bit folds in the bit above.
    assign bin_out[WIDTH-1] = gray_in[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_chain
            assign bin_out[gi] = bin_out[gi+1] ^ gray_in[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/binary_to_gray_converter.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_gray_converter
//  Description : Registered binary<->Gray converter with one cycle of latency.
//                mode selects the direction per word; results and the input
//                parity hold while no new word is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_to_gray_converter
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    binary_to_gray_converter_if.slave   bus
);

    logic [WIDTH-1:0] w_bin2gray;
    logic [WIDTH-1:0] w_gray2bin;
    logic [WIDTH-1:0] w_result;
    logic             w_parity;

    logic [WIDTH-1:0] r_g;
    logic             r_out_valid;
    logic             r_parity;

    // Encode path: logical right shift brings a zero into the MSB.
    assign w_bin2gray = bus.b ^ (bus.b >> 1);

    gray_xor_prefix #(
        .WIDTH   (WIDTH)
    ) u_xor_prefix (
        .gray_in (bus.b),
        .bin_out (w_gray2bin)
    );

    // Mode is sampled alongside the word, so direction can change every cycle.
    assign w_result = (bus.mode == MODE_GRAY2BIN) ? w_gray2bin : w_bin2gray;
    assign w_parity = ^bus.b;

    // Output registers: load on valid, hold otherwise; valid strobes one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g         <= '0;
            r_out_valid <= 1'b0;
            r_parity    <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_g      <= w_result;
                r_parity <= w_parity;
            end
        end
    end

    assign bus.g         = r_g;
    assign bus.out_valid = r_out_valid;
    assign bus.parity    = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_gray_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_to_gray_converter
//  Description : Directed self-checking bench for binary_to_gray_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_to_gray_converter;

    localparam int W = 3;

    typedef struct {
        logic [W-1:0] g;
        logic         ov;
        logic         p;
        string        tag;
    } exp_t;

    logic clk;
    logic rst_n;

    binary_to_gray_converter_if #(.WIDTH(W)) bus ();

    binary_to_gray_converter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           n_cmp;
    int           n_err;
    logic [W-1:0] held_g;
    logic         held_p;

    function automatic logic xor_bits(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < W; i++) r = r ^ v[i];
        return r;
    endfunction

    // One clock: drive at negedge, push expectation, compare #1 after posedge.
    task automatic cycle(input logic rst_val, input logic vld, input logic md,
                         input logic [W-1:0] word, input logic [W-1:0] exp_g,
                         input string tag);
        exp_t e;
        exp_t o;
        @(negedge clk);
        rst_n       = rst_val;
        bus.in_valid = vld;
        bus.mode    = md;
        bus.b       = word;
        if (!rst_val) begin
            held_g = '0;
            held_p = 1'b0;
            e.ov   = 1'b0;
        end else if (vld) begin
            held_g = exp_g;
            held_p = xor_bits(word);
            e.ov   = 1'b1;
        end else begin
            e.ov   = 1'b0;
        end
        e.g   = held_g;
        e.p   = held_p;
        e.tag = tag;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, observed g=%b required an entry", tag, bus.g);
        end else begin
            o = sb.pop_front();
            n_cmp++;
            assert (bus.g === o.g) else begin
                n_err++;
                $display("FAIL %s.g: observed %b expected %b", o.tag, bus.g, o.g);
                $error("g check %s", o.tag);
            end
            n_cmp++;
            assert (bus.out_valid === o.ov) else begin
                n_err++;
                $display("FAIL %s.out_valid: observed %b expected %b", o.tag, bus.out_valid, o.ov);
                $error("out_valid check %s", o.tag);
            end
            n_cmp++;
            assert (bus.parity === o.p) else begin
                n_err++;
                $display("FAIL %s.parity: observed %b expected %b", o.tag, bus.parity, o.p);
                $error("parity check %s", o.tag);
            end
        end
    endtask

    logic [W-1:0] gray_tab [8];
    logic [W-1:0] bin_tab  [8];

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        held_g = '0;
        held_p = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.b        = '0;

        gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        bin_tab  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

        // Reset held with valid input present
        cycle(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "reset0");
        cycle(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "reset1");

        // Binary -> Gray sweep
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 3'(i), gray_tab[i], $sformatf("b2g_%0d", i));
        end

        // Gray -> binary sweep
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1, gray_tab[i], bin_tab[i], $sformatf("g2b_%0d", i));
        end

        // Hold behaviour
        cycle(1'b1, 1'b1, 1'b0, 3'b101, 3'b111, "hold_load");
        cycle(1'b1, 1'b0, 1'b0, 3'b010, 3'b000, "hold_idle");
        cycle(1'b1, 1'b0, 1'b1, 3'b110, 3'b000, "hold_idle2");

        // Back-to-back mode switch (round trip)
        cycle(1'b1, 1'b1, 1'b0, 3'b110, 3'b101, "rt_enc");
        cycle(1'b1, 1'b1, 1'b1, 3'b101, 3'b110, "rt_dec");

        // Reset mid-stream
        cycle(1'b1, 1'b1, 1'b0, 3'b001, 3'b001, "mid_a");
        cycle(1'b1, 1'b1, 1'b0, 3'b010, 3'b011, "mid_b");
        cycle(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "mid_rst");
        cycle(1'b1, 1'b1, 1'b0, 3'b011, 3'b010, "post_rst");
        cycle(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, "post_idle");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
